// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-state data-memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // byte-lane bits below the word index
  localparam int LANE_W = 2;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // first byte-address bit that must be zero for an in-range access
  function automatic int top_bit(input int depth);
    return idx_w(depth) + LANE_W;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-enable / store replication and load lane extraction with sign or zero extension.
// Low address bits not meaningful for the access size are ignored (word: both, half: bit 0).
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be        = 4'b0000;
    wdata_rep = '0;
    rdata     = '0;
    byte_sel  = rword[{lane, 3'b000} +: 8];
    half_sel  = lane[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata     = rword;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = '0;
        rdata     = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Valid/ready data-memory controller with configurable wait states and error responses.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
//
// state  | meaning
// IDLE   | ready for a request
// WAIT   | counting wait states for the captured request
// RESP   | response held until the consumer takes it
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IW  = idx_w(DEPTH);
  localparam int TOP = top_bit(DEPTH);

  state_t            state;
  logic [3:0]        cnt;
  logic              q_we;
  logic [1:0]        q_size;
  logic              q_uns;
  logic [ADDR_W-1:0] q_addr;
  logic [DATA_W-1:0] q_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              go_resp;
  logic              c_we;
  logic [1:0]        c_size;
  logic              c_uns;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [IW-1:0]     c_idx;
  logic              c_oor;
  logic              c_misal;
  logic              c_err;
  logic [3:0]        be;
  logic [DATA_W-1:0] wrep;
  logic [DATA_W-1:0] lane_rdata;

  assign req_ready = (state == S_IDLE) && !rst;
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid && req_ready;
  assign go_resp   = ((state == S_IDLE) && accept && (WAIT_STATES == 0)) ||
                     ((state == S_WAIT) && (cnt == 4'd0));

  // live inputs feed the zero-wait path straight from IDLE; otherwise use the captured copy
  always_comb begin
    if (state == S_IDLE) begin
      c_we    = req_we;
      c_size  = req_size;
      c_uns   = req_unsigned;
      c_addr  = req_addr;
      c_wdata = req_wdata;
    end else begin
      c_we    = q_we;
      c_size  = q_size;
      c_uns   = q_uns;
      c_addr  = q_addr;
      c_wdata = q_wdata;
    end
  end

  assign c_idx = c_addr[TOP-1:LANE_W];

  generate
    if (ADDR_W > TOP) begin : g_oor
      assign c_oor = |c_addr[ADDR_W-1:TOP];
    end else begin : g_no_oor
      assign c_oor = 1'b0;
    end
  endgenerate

`ifdef DMEM_ALIGN_CHECK_EN
  assign c_misal = ((c_size == SZ_HALF) && c_addr[0]) ||
                   ((c_size == SZ_WORD) && (c_addr[1:0] != 2'b00));
`else
  assign c_misal = 1'b0;
`endif

  assign c_err = c_oor || (c_size == SZ_RSVD) || c_misal;

  dmem_lane u_lane (
    .size        (c_size),
    .is_unsigned (c_uns),
    .lane        (c_addr[1:0]),
    .wdata       (c_wdata),
    .rword       (mem[c_idx]),
    .be          (be),
    .wdata_rep   (wrep),
    .rdata       (lane_rdata)
  );

  always_ff @(posedge clk) begin
    if (go_resp && c_we && !c_err) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[c_idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      q_we      <= 1'b0;
      q_size    <= SZ_BYTE;
      q_uns     <= 1'b0;
      q_addr    <= '0;
      q_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            q_we    <= req_we;
            q_size  <= req_size;
            q_uns   <= req_unsigned;
            q_addr  <= req_addr;
            q_wdata <= req_wdata;
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (go_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= c_err;
        rsp_rdata <= (c_we || c_err) ? '0 : lane_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: byte-array reference model plus directed transactions.
module tb_dmem_ctrl;

  localparam int WS    = 2;
  localparam int DEPTH = 256;
  localparam int NB    = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  dmem_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: byte-addressed memory, response due WS edges after the accept edge
  logic [7:0]  bm [NB];
  logic        m_busy = 1'b0, m_valid = 1'b0, m_err = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_we, m_uns;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  longint      cyc = 0, m_due = 0;

  task automatic resolve();
    int n;
    logic [31:0] a;
    longint v;
    logic bad;
    n = 1 << m_size;
    a = m_addr;
    bad = (a >= NB) || (m_size == 2'b11);
`ifdef DMEM_ALIGN_CHECK_EN
    if (m_size != 2'b11 && (a % n) != 0) bad = 1'b1;
`else
    if (m_size != 2'b11) a = a - (a % n);
`endif
    m_err = bad;
    m_rdata = '0;
    if (!bad) begin
      if (m_we) begin
        for (int i = 0; i < n; i++) bm[a + i] = m_wdata[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(bm[a + i]) << (8 * i));
        if (!m_uns && v[8*n-1]) v = v | ~((longint'(1) << (8 * n)) - 1);
        m_rdata = v[31:0];
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_valid = 1'b0;
    end else begin
      cyc++;
      if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
        m_busy = 1'b0;
      end else if (m_busy && !m_valid && cyc == m_due) begin
        m_valid = 1'b1;
        resolve();
      end else if (!m_busy && req_valid) begin
        m_busy = 1'b1;
        m_we = req_we; m_size = req_size; m_uns = req_unsigned;
        m_addr = req_addr; m_wdata = req_wdata;
        m_due = cyc + WS;
        if (WS == 0) begin
          m_valid = 1'b1;
          resolve();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, !m_busy});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
      end
    end
  end

  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    rsp_ready = (hold == 0);
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_err", {31'd0, rsp_err}, {31'd0, er});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_busy", {31'd0, busy}, 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rsp_done", {31'd0, rsp_valid}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    txn(1, 2'b10, 0, 32'h0,  32'h01234567, 0, rd, er, lat);
    txn(1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 0, rd, er, lat);
    txn(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
    chk("st_word_lat", lat, 32'd3);
    chk("st_word_rdata", rd, 32'd0);
    chk("st_word_err", {31'd0, er}, 32'd0);
    txn(0, 2'b10, 0, 32'h10, 32'h0, 0, rd, er, lat);
    chk("ld_word_lat", lat, 32'd3);
    chk("ld_word_10", rd, 32'hDEADBEEF);
    chk("ld_word_err", {31'd0, er}, 32'd0);

    txn(1, 2'b00, 0, 32'h13, 32'h0000005A, 0, rd, er, lat);
    txn(1, 2'b00, 0, 32'h12, 32'hFFFFFF80, 0, rd, er, lat);
    txn(0, 2'b00, 0, 32'h12, 32'h0, 0, rd, er, lat);
    chk("ld_sbyte_12", rd, 32'hFFFFFF80);
    txn(0, 2'b00, 1, 32'h12, 32'h0, 0, rd, er, lat);
    chk("ld_ubyte_12", rd, 32'h00000080);
    txn(0, 2'b10, 0, 32'h10, 32'h0, 0, rd, er, lat);
    chk("ld_word_merged", rd, 32'h5A80BEEF);

    txn(0, 2'b01, 0, 32'h11, 32'h0, 0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("ld_half_11_err", {31'd0, er}, 32'd1);
    chk("ld_half_11_rdata", rd, 32'd0);
`else
    chk("ld_half_11_err", {31'd0, er}, 32'd0);
    chk("ld_half_11_rdata", rd, 32'hFFFFBEEF);
`endif
    txn(0, 2'b01, 0, 32'h12, 32'h0, 0, rd, er, lat);
    chk("ld_shalf_12", rd, 32'h00005A80);
    txn(0, 2'b01, 0, 32'h10, 32'h0, 0, rd, er, lat);
    chk("ld_shalf_10", rd, 32'hFFFFBEEF);
    txn(0, 2'b01, 1, 32'h10, 32'h0, 0, rd, er, lat);
    chk("ld_uhalf_10", rd, 32'h0000BEEF);

    txn(1, 2'b00, 0, 32'h400, 32'h1, 0, rd, er, lat);
    chk("st_oor_err", {31'd0, er}, 32'd1);
    txn(0, 2'b10, 0, 32'h0, 32'h0, 0, rd, er, lat);
    chk("ld_word_0_intact", rd, 32'h01234567);
    txn(0, 2'b11, 0, 32'h10, 32'h0, 0, rd, er, lat);
    chk("rsvd_size_err", {31'd0, er}, 32'd1);
    chk("rsvd_size_rdata", rd, 32'd0);
    txn(0, 2'b10, 0, 32'h8000_0010, 32'h0, 0, rd, er, lat);
    chk("ld_high_bit_err", {31'd0, er}, 32'd1);
    txn(1, 2'b10, 0, 32'h3FC, 32'hA5A55A5A, 0, rd, er, lat);
    txn(0, 2'b10, 0, 32'h3FC, 32'h0, 0, rd, er, lat);
    chk("ld_top_word", rd, 32'hA5A55A5A);

    txn(0, 2'b10, 0, 32'h10, 32'h0, 3, rd, er, lat);
    chk("hold_ld_word", rd, 32'h5A80BEEF);

    // reset while a store sits in WAIT
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait_busy", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_rsp_rdata", rsp_rdata, 32'd0);
    chk("arst_rsp_err", {31'd0, rsp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    txn(0, 2'b10, 0, 32'h20, 32'h0, 0, rd, er, lat);
    chk("ld_after_rst", rd, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
